// File: rtl/ham_codeword_writer_if.sv
// ============================================================================
// Module      : ham_codeword_writer_if
// Description : Control, data-memory and parity-generator signals of the
//               Hamming codeword writer, bundled for port connection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ham_codeword_writer_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic [7:0] par_a;
    logic [7:0] par_b;
    logic [4:0] parity_in;

    // Environment side: issues Start, returns memory read data and parity.
    modport master (
        output start,
        output mem_rd_data,
        output parity_in,
        input  busy,
        input  done,
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wr_data,
        input  par_a,
        input  par_b
    );

    // Writer side.
    modport slave (
        input  start,
        input  mem_rd_data,
        input  parity_in,
        output busy,
        output done,
        output mem_addr,
        output mem_wr_en,
        output mem_wr_data,
        output par_a,
        output par_b
    );
endinterface

`default_nettype wire

// File: rtl/ham_codeword_writer.sv
// ============================================================================
// Module      : ham_codeword_writer
// Description : Reads MSG_COUNT two-byte 11-bit messages from data memory,
//               presents them to an external parity generator, assembles
//               the 16-bit Hamming codeword and writes it back as two bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ham_codeword_writer #(
    parameter int MSG_COUNT = 30,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 60
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    ham_codeword_writer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_CAP   = 3'd3,
        S_CALC  = 3'd4,
        S_WR_LO = 3'd5,
        S_WR_HI = 3'd6,
        S_FIN   = 3'd7
    } state_t;

    // Base addresses wrap into the 8-bit address space.
    localparam logic [7:0] C_SRC_BASE = 8'(SRC_BASE);
    localparam logic [7:0] C_DST_BASE = 8'(DST_BASE);
    localparam logic [7:0] C_LAST_IDX = 8'(MSG_COUNT - 1);
    localparam bit         C_EMPTY    = (MSG_COUNT == 0);

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  par_a_q, par_a_d;
    logic [7:0]  par_b_q, par_b_d;
    logic [15:0] cw_q, cw_d;

    logic [7:0]  w_idx_x2;
    logic [7:0]  w_src_lo;
    logic [7:0]  w_dst_lo;
    logic        w_busy;
    logic        w_done;
    logic        w_wr_en;
    logic [7:0]  w_addr;
    logic [7:0]  w_wr_data;

    // Byte offset of the current message; modulo-256 arithmetic by width.
    assign w_idx_x2 = {idx_q[6:0], 1'b0};
    assign w_src_lo = C_SRC_BASE + w_idx_x2;
    assign w_dst_lo = C_DST_BASE + w_idx_x2;

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            par_a_q <= '0;
            par_b_q <= '0;
            cw_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            par_a_q <= par_a_d;
            par_b_q <= par_b_d;
            cw_q    <= cw_d;
        end
    end

    // Next-state, datapath capture and per-state output decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        par_a_d   = par_a_q;
        par_b_d   = par_b_q;
        cw_d      = cw_q;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_wr_en   = 1'b0;
        w_addr    = 8'h00;
        w_wr_data = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    idx_d   = 8'h00;
                    state_d = C_EMPTY ? S_FIN : S_RD_LO;
                end
            end
            S_RD_LO: begin
                w_busy  = 1'b1;
                w_addr  = w_src_lo;
                state_d = S_RD_HI;
            end
            S_RD_HI: begin
                // Read data now carries the low byte addressed in RD_LO.
                w_busy  = 1'b1;
                w_addr  = w_src_lo + 8'h01;
                par_b_d = bus.mem_rd_data;
                state_d = S_CAP;
            end
            S_CAP: begin
                // Only b11..b9 live in the high byte; the rest is discarded.
                w_busy  = 1'b1;
                par_a_d = {5'b00000, bus.mem_rd_data[2:0]};
                state_d = S_CALC;
            end
            S_CALC: begin
                // parity_in = {p16,p8,p4,p2,p1}; interleave with data bits.
                w_busy  = 1'b1;
                cw_d    = {par_a_q[2:0], par_b_q[7:4], bus.parity_in[3],
                           par_b_q[3:1], bus.parity_in[2], par_b_q[0],
                           bus.parity_in[1], bus.parity_in[0],
                           bus.parity_in[4]};
                state_d = S_WR_LO;
            end
            S_WR_LO: begin
                w_busy    = 1'b1;
                w_wr_en   = 1'b1;
                w_addr    = w_dst_lo;
                w_wr_data = cw_q[7:0];
                state_d   = S_WR_HI;
            end
            S_WR_HI: begin
                w_busy    = 1'b1;
                w_wr_en   = 1'b1;
                w_addr    = w_dst_lo + 8'h01;
                w_wr_data = cw_q[15:8];
                if (idx_q == C_LAST_IDX) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = S_RD_LO;
                end
            end
            S_FIN: begin
                w_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.mem_wr_en   = w_wr_en;
    assign bus.mem_addr    = w_addr;
    assign bus.mem_wr_data = w_wr_data;
    assign bus.par_a       = par_a_q;
    assign bus.par_b       = par_b_q;

endmodule

`default_nettype wire

// File: tb/tb_ham_codeword_writer.sv
// ============================================================================
// Module      : tb_ham_codeword_writer
// Description : Scoreboard bench for ham_codeword_writer with a reference
//               Hamming generator and codeword layout model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ham_codeword_writer;

    localparam int N = 30;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ham_codeword_writer_if bus ();
    ham_codeword_writer_if bus0 ();

    ham_codeword_writer #(.MSG_COUNT(N), .SRC_BASE(0), .DST_BASE(60)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    ham_codeword_writer #(.MSG_COUNT(0), .SRC_BASE(0), .DST_BASE(60)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    logic [7:0]  mem [0:255];
    logic [7:0]  rd_q;
    logic        par_force;
    logic [4:0]  par_val;

    int          checks   = 0;
    int          failures = 0;
    int          n_done   = 0;
    int          wr_count = 0;
    logic [15:0] exp_wr[$];
    int          exp_done[$];

    // Standard Hamming(15,11) layout: data at non-power-of-two positions,
    // p(2^j) covers positions with bit j set, p16 is overall parity.
    function automatic logic [4:0] hamming_parity(input logic [10:0] msg);
        logic [15:0] v;
        logic [4:0]  p;
        int          k;
        v = '0;
        p = '0;
        k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                v[pos] = msg[k];
                k++;
            end
        end
        for (int j = 0; j < 4; j++)
            for (int pos = 1; pos < 16; pos++)
                if (((pos >> j) & 1) == 1) p[j] = p[j] ^ v[pos];
        for (int j = 0; j < 4; j++) v[1 << j] = p[j];
        p[4] = ^v[15:1];
        return p;
    endfunction

    // Codeword = Hamming positions 15..1 with p16 placed at bit 0.
    function automatic logic [15:0] expected_cw(input logic [10:0] msg,
                                                input logic [4:0]  par);
        logic [15:0] cw;
        int          k;
        cw = '0;
        k  = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) == 0) begin
                cw[pos] = par[$clog2(pos)];
            end else begin
                cw[pos] = msg[k];
                k++;
            end
        end
        cw[0] = par[4];
        return cw;
    endfunction

    // Environment: synchronous-read memory and combinational parity source.
    always @(posedge clk) rd_q <= mem[bus.mem_addr];
    assign bus.mem_rd_data = rd_q;
    always_comb begin
        bus.parity_in = par_force ? par_val
                                  : hamming_parity({bus.par_a[2:0], bus.par_b});
    end
    assign bus0.mem_rd_data = 8'h00;
    assign bus0.parity_in   = 5'b00000;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic       s_en;
        logic [7:0] s_addr;
        logic [7:0] s_data;
        logic [7:0] s_a;
        logic       s_done;
        logic       s_busy;
        logic [15:0] e;
        int         ed;
        forever begin
            @(negedge clk);
            s_en   = bus.mem_wr_en;
            s_addr = bus.mem_addr;
            s_data = bus.mem_wr_data;
            s_a    = bus.par_a;
            s_done = bus.done;
            s_busy = bus.busy;
            chk("par_a_upper_zero", {27'd0, s_a[7:3]}, 0);
            if (s_done) begin
                n_done++;
                chk("busy_low_at_done", {31'd0, s_busy}, 0);
                if (exp_done.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected actual=pulse@%0d expected=none", cyc);
                end else begin
                    ed = exp_done.pop_front();
                    chk("done_cycle", cyc, ed);
                end
            end
            // A write takes effect only if reset is still released at the edge.
            @(posedge clk);
            if (rst_n && s_en) begin
                wr_count++;
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected actual addr=0x%0h data=0x%0h expected=none",
                             s_addr, s_data);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", {24'd0, s_addr}, {24'd0, e[15:8]});
                    chk("wr_data", {24'd0, s_data}, {24'd0, e[7:0]});
                end
            end
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < 2 * N; i++) mem[i] = 8'($urandom);
    endtask

    task automatic push_run(input int s, input int nmsg, input bit with_done);
        logic [10:0] m;
        logic [4:0]  p;
        logic [15:0] cw;
        for (int i = 0; i < nmsg; i++) begin
            m  = {mem[2*i+1][2:0], mem[2*i]};
            p  = par_force ? par_val : hamming_parity(m);
            cw = expected_cw(m, p);
            exp_wr.push_back({8'(60 + 2*i), cw[7:0]});
            exp_wr.push_back({8'(61 + 2*i), cw[15:8]});
        end
        if (with_done) exp_done.push_back(s + 6 * N);
    endtask

    // Returns at the negedge of the first cycle after acceptance (RD_LO).
    task automatic start_pulse(output int s);
        @(negedge clk);
        bus.start = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (n_done < target && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("run_done_count", n_done, target);
        @(negedge clk);
    endtask

    task automatic run_full(input bit frc, input logic [4:0] pv,
                            input bit directed, input logic [7:0] lo,
                            input logic [7:0] hi);
        int s;
        int w0;
        int d0;
        load_mem();
        if (directed) begin
            mem[0] = lo;
            mem[1] = hi;
        end
        par_force = frc;
        par_val   = pv;
        w0 = wr_count;
        d0 = n_done;
        start_pulse(s);
        push_run(s, N, 1'b1);
        chk("busy_first_cycle", {31'd0, bus.busy}, 1);
        repeat (3) @(negedge clk);
        chk("par_a_msg0", {24'd0, bus.par_a}, {29'd0, mem[1][2:0]});
        chk("par_b_msg0", {24'd0, bus.par_b}, {24'd0, mem[0]});
        wait_done(d0 + 1);
        chk("write_strobes", wr_count - w0, 2 * N);
    endtask

    initial begin
        int s;
        int s2;
        int w0;
        int d0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus0.start = 1'b0;
        par_force  = 1'b0;
        par_val    = 5'b00000;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        fork
            monitor();
        join_none

        // Reset state.
        @(negedge clk);
        chk("rst_busy",  {31'd0, bus.busy}, 0);
        chk("rst_done",  {31'd0, bus.done}, 0);
        chk("rst_wr_en", {31'd0, bus.mem_wr_en}, 0);
        chk("rst_addr",  {24'd0, bus.mem_addr}, 0);
        chk("rst_wdata", {24'd0, bus.mem_wr_data}, 0);
        chk("rst_par_a", {24'd0, bus.par_a}, 0);
        chk("rst_par_b", {24'd0, bus.par_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed patterns with a forced parity value.
        run_full(1'b1, 5'b00000, 1'b1, 8'h00, 8'h00);
        run_full(1'b1, 5'b11111, 1'b1, 8'hFF, 8'h07);
        run_full(1'b1, 5'b10101, 1'b1, 8'h00, 8'hF8);
        chk("cw_req036_lo", {16'd0, expected_cw(11'h000, 5'b10101)}, 32'h0013);

        // Random message contents with the reference Hamming generator.
        for (int r = 0; r < 3; r++) run_full(1'b0, 5'b00000, 1'b0, 8'h00, 8'h00);

        // Reset during WR_LO of message 5 (address 70).
        load_mem();
        par_force = 1'b0;
        w0 = wr_count;
        start_pulse(s);
        push_run(s, 5, 1'b0);
        while (cyc < s + 34) @(negedge clk);
        chk("abort_pre_addr",  {24'd0, bus.mem_addr}, 70);
        chk("abort_pre_wr_en", {31'd0, bus.mem_wr_en}, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy",  {31'd0, bus.busy}, 0);
        chk("abort_done",  {31'd0, bus.done}, 0);
        chk("abort_wr_en", {31'd0, bus.mem_wr_en}, 0);
        chk("abort_addr",  {24'd0, bus.mem_addr}, 0);
        chk("abort_wdata", {24'd0, bus.mem_wr_data}, 0);
        chk("abort_par_a", {24'd0, bus.par_a}, 0);
        chk("abort_par_b", {24'd0, bus.par_b}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_writes", wr_count - w0, 10);
        chk("abort_queue_drained", exp_wr.size(), 0);
        load_mem();
        d0 = n_done;
        start_pulse(s);
        push_run(s, N, 1'b1);
        chk("restart_addr0", {24'd0, bus.mem_addr}, 0);
        wait_done(d0 + 1);

        // Start held high: second run only after FIN returns to IDLE.
        load_mem();
        d0 = n_done;
        @(negedge clk);
        bus.start = 1'b1;
        s  = cyc + 1;
        s2 = s + 6 * N + 2;
        push_run(s, N, 1'b1);
        push_run(s2, N, 1'b1);
        while (cyc < s + 6 * N + 1) @(negedge clk);
        chk("held_idle_busy", {31'd0, bus.busy}, 0);
        chk("held_idle_wr_en", {31'd0, bus.mem_wr_en}, 0);
        while (cyc < s2 + 6 * N) @(negedge clk);
        bus.start = 1'b0;
        wait_done(d0 + 2);

        // MSG_COUNT = 0: straight to FIN, no memory access.
        @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        chk("empty_done",  {31'd0, bus0.done}, 1);
        chk("empty_busy",  {31'd0, bus0.busy}, 0);
        chk("empty_wr_en", {31'd0, bus0.mem_wr_en}, 0);
        chk("empty_addr",  {24'd0, bus0.mem_addr}, 0);
        @(negedge clk);
        chk("empty_done_pulse", {31'd0, bus0.done}, 0);

        repeat (3) @(negedge clk);
        chk("final_wr_queue", exp_wr.size(), 0);
        chk("final_done_queue", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
